// File: rtl/pcd_sequence_decode.sv
// Modified-Miller (ISO/IEC 14443A PCD->PICC) sequence decoder: X/Y/Z to soc/data/eoc/error events.
// Optional sequence monitor outputs enabled by defining SEQ_DECODE_SEQ_OUT_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// ST_IDLE   | no frame; first pause edge gives soc
// ST_ACTIVE | in frame; each identified sequence releases the previous bit
// ST_ERR    | illegal sequence seen; keep tracking until Y after Z/Y ends frame
module pcd_sequence_decode #(
   parameter int BIT_LEN = 128
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pause_n_synchronised,
   output logic       soc,
   output logic       eoc,
   output logic       data,
   output logic       data_valid,
   output logic       error
`ifdef SEQ_DECODE_SEQ_OUT_EN
   ,
   output logic       seq_valid,
   output logic [1:0] seq_type
`endif
);

   localparam int CW = $clog2(BIT_LEN);
   localparam int Q  = BIT_LEN / 4;
   localparam logic [CW-1:0] C_Q     = CW'(Q);
   localparam logic [CW-1:0] C_3Q    = CW'(3 * Q);
   localparam logic [CW-1:0] C_3Q_M1 = CW'(3 * Q - 1);
   localparam logic [CW-1:0] C_HALF  = CW'(BIT_LEN / 2);
   localparam logic [CW-1:0] C_LAST  = CW'(BIT_LEN - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_ERR} state_t;
   typedef enum logic [1:0] {SEQ_Z = 2'd0, SEQ_X = 2'd1, SEQ_Y = 2'd2, SEQ_SOC = 2'd3} seq_t;

   state_t        state, state_nxt;
   seq_t          prev, prev_nxt;
   seq_t          id_seq;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          pause_seen, ps_nxt;
   logic          pin_q;
   logic          err_pend, err_pend_nxt;
   logic          soc_nxt, eoc_nxt, data_nxt, dv_nxt, err_nxt;
   logic          pause_edge;
   logic          id_vld;
   logic          bad_pause;
`ifdef SEQ_DECODE_SEQ_OUT_EN
   logic          sv_nxt;
   logic [1:0]    st_nxt;
`endif

   assign pause_edge = pin_q & ~pause_n_synchronised;

   always_comb begin
      state_nxt    = state;
      prev_nxt     = prev;
      cnt_nxt      = (cnt == C_LAST) ? '0 : cnt + 1'b1;
      ps_nxt       = (cnt == C_LAST) ? 1'b0 : pause_seen;
      err_pend_nxt = 1'b0;
      soc_nxt      = 1'b0;
      eoc_nxt      = 1'b0;
      data_nxt     = 1'b0;
      dv_nxt       = 1'b0;
      err_nxt      = err_pend;
      id_vld       = 1'b0;
      id_seq       = SEQ_Y;
      bad_pause    = 1'b0;
`ifdef SEQ_DECODE_SEQ_OUT_EN
      sv_nxt       = 1'b0;
      st_nxt       = 2'd0;
`endif

      // Sequence classification; every accepted pause resynchronises the bit counter.
      if (state != ST_IDLE) begin
         if (pause_edge) begin
            if (cnt >= C_3Q) begin
               id_vld  = 1'b1;
               id_seq  = SEQ_Z;
               cnt_nxt = '0;
               ps_nxt  = 1'b1;
            end else if (pause_seen) begin
               bad_pause = 1'b1;
            end else if (cnt < C_Q) begin
               id_vld  = 1'b1;
               id_seq  = SEQ_Z;
               cnt_nxt = '0;
               ps_nxt  = 1'b1;
            end else begin
               id_vld  = 1'b1;
               id_seq  = SEQ_X;
               cnt_nxt = C_HALF;
               ps_nxt  = 1'b1;
            end
         end else if (cnt == C_3Q_M1 && !pause_seen) begin
            id_vld = 1'b1;
            id_seq = SEQ_Y;
         end
      end

      case (state)
         ST_IDLE: begin
            cnt_nxt = '0;
            ps_nxt  = 1'b0;
            if (pause_edge) begin
               soc_nxt   = 1'b1;
               state_nxt = ST_ACTIVE;
               prev_nxt  = SEQ_SOC;
               ps_nxt    = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (bad_pause) begin
               err_nxt   = 1'b1;
               state_nxt = ST_ERR;
            end else if (id_vld) begin
               if (id_seq == SEQ_Y && prev != SEQ_X) begin
                  eoc_nxt   = 1'b1;
                  state_nxt = ST_IDLE;
               end else if (id_seq == SEQ_Z && prev == SEQ_X) begin
                  // The pending X still goes out; the error follows it one cycle later.
                  dv_nxt       = 1'b1;
                  data_nxt     = 1'b1;
                  err_pend_nxt = 1'b1;
                  prev_nxt     = SEQ_Z;
                  state_nxt    = ST_ERR;
               end else begin
                  if (prev != SEQ_SOC) begin
                     dv_nxt   = 1'b1;
                     data_nxt = (prev == SEQ_X);
                  end
                  prev_nxt = id_seq;
               end
            end
         end
         ST_ERR: begin
            if (id_vld) begin
               if (id_seq == SEQ_Y && (prev == SEQ_Z || prev == SEQ_Y)) begin
                  eoc_nxt   = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  prev_nxt = id_seq;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

`ifdef SEQ_DECODE_SEQ_OUT_EN
      if (state == ST_IDLE) begin
         sv_nxt = pause_edge;
         st_nxt = 2'd0;
      end else begin
         sv_nxt = id_vld;
         st_nxt = id_vld ? id_seq : 2'd0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         prev       <= SEQ_SOC;
         cnt        <= '0;
         pause_seen <= 1'b0;
         pin_q      <= 1'b0;
         err_pend   <= 1'b0;
         soc        <= 1'b0;
         eoc        <= 1'b0;
         data       <= 1'b0;
         data_valid <= 1'b0;
         error      <= 1'b0;
`ifdef SEQ_DECODE_SEQ_OUT_EN
         seq_valid  <= 1'b0;
         seq_type   <= 2'd0;
`endif
      end else begin
         state      <= state_nxt;
         prev       <= prev_nxt;
         cnt        <= cnt_nxt;
         pause_seen <= ps_nxt;
         pin_q      <= pause_n_synchronised;
         err_pend   <= err_pend_nxt;
         soc        <= soc_nxt;
         eoc        <= eoc_nxt;
         data       <= data_nxt;
         data_valid <= dv_nxt;
         error      <= err_nxt;
`ifdef SEQ_DECODE_SEQ_OUT_EN
         seq_valid  <= sv_nxt;
         seq_type   <= st_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_pcd_sequence_decode.sv
// Directed bench for pcd_sequence_decode: drives modified-Miller waveforms and checks the event stream.
module tb_pcd_sequence_decode;

   localparam int K_Z = 0, K_X = 1, K_Y = 2, K_ZX = 3;
   localparam int E_SOC = 10, E_EOC = 11, E_ERR = 12;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic pause_n = 1'b1;
   logic soc, eoc, data, data_valid, error;
`ifdef SEQ_DECODE_SEQ_OUT_EN
   logic       seq_valid;
   logic [1:0] seq_type;
`endif

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int viol = 0;
   int log_q[$];
   int stamp_q[$];
   logic soc_d = 1'b0, eoc_d = 1'b0, dv_d = 1'b0, err_d = 1'b0;

   pcd_sequence_decode #(.BIT_LEN(128)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .pause_n_synchronised(pause_n),
      .soc(soc),
      .eoc(eoc),
      .data(data),
      .data_valid(data_valid),
      .error(error)
`ifdef SEQ_DECODE_SEQ_OUT_EN
      ,
      .seq_valid(seq_valid),
      .seq_type(seq_type)
`endif
   );

   always #5 clk = ~clk;

   // Event logger and pulse-rule watcher, sampled on the falling edge.
   always @(negedge clk) begin
      cyc++;
      if ((int'(soc) + int'(eoc) + int'(data_valid) + int'(error)) > 1) viol++;
      if ((soc && soc_d) || (eoc && eoc_d) || (data_valid && dv_d) || (error && err_d)) viol++;
      if (soc)        begin log_q.push_back(E_SOC);      stamp_q.push_back(cyc); end
      if (data_valid) begin log_q.push_back(int'(data)); stamp_q.push_back(cyc); end
      if (eoc)        begin log_q.push_back(E_EOC);      stamp_q.push_back(cyc); end
      if (error)      begin log_q.push_back(E_ERR);      stamp_q.push_back(cyc); end
      soc_d = soc;
      eoc_d = eoc;
      dv_d  = data_valid;
      err_d = error;
   end

   task automatic send(input int kind, input int len, input int plen);
      logic low;
      for (int i = 0; i < len; i++) begin
         @(posedge clk);
         #1;
         low = ((kind == K_Z || kind == K_ZX) && i < plen) ||
               ((kind == K_X || kind == K_ZX) && i >= len / 2 && i < len / 2 + plen);
         pause_n = ~low;
      end
   endtask

   task automatic send_list(input int k[$], input int len, input int plen);
      foreach (k[i]) send(k[i], len, plen);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         pause_n = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      pause_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         total++;
         if ({soc, eoc, data, data_valid, error} !== 5'b0) begin
            bad++;
            $display("FAIL reset_outputs: got=%b want=00000", {soc, eoc, data, data_valid, error});
         end
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      begin
         int base = log_q.size();
         idle(400);
         total++;
         if (log_q.size() !== base) begin
            bad++;
            $display("FAIL idle_quiet: got=%0d events want=0", log_q.size() - base);
         end
      end
   endtask

   task automatic test_basic_frame();
      int seq[$];
      int exp[$];
      int base, n;
      seq = '{K_Z, K_Z, K_X, K_X, K_Y, K_Z, K_X, K_Y, K_X, K_Y, K_Y};
      exp = '{E_SOC, 0, 1, 1, 0, 0, 1, 0, 1, E_EOC};
      base = log_q.size();
      send_list(seq, 128, 20);
      idle(300);
      n = log_q.size() - base;
      total++;
      if (n !== exp.size()) begin
         bad++;
         $display("FAIL basic_count: got=%0d want=%0d", n, exp.size());
      end
      for (int i = 0; i < n && i < exp.size(); i++) begin
         total++;
         if (log_q[base + i] !== exp[i]) begin
            bad++;
            $display("FAIL basic_event[%0d]: got=%0d want=%0d", i, log_q[base + i], exp[i]);
         end
      end
   endtask

   task automatic test_eoc_absorb();
      int seq[$];
      int exp[$];
      int base, n;
      seq = '{K_Z, K_X, K_Y, K_Z, K_Y, K_Y};
      exp = '{E_SOC, 1, 0, E_EOC};
      base = log_q.size();
      send_list(seq, 128, 14);
      idle(300);
      n = log_q.size() - base;
      total++;
      if (n !== exp.size()) begin
         bad++;
         $display("FAIL absorb_count: got=%0d want=%0d", n, exp.size());
      end
      for (int i = 0; i < n && i < exp.size(); i++) begin
         total++;
         if (log_q[base + i] !== exp[i]) begin
            bad++;
            $display("FAIL absorb_event[%0d]: got=%0d want=%0d", i, log_q[base + i], exp[i]);
         end
      end
   endtask

   task automatic test_error_after_x();
      int seq[$];
      int exp[$];
      int base, n;
      seq = '{K_Z, K_X, K_Z, K_Z, K_X, K_Y, K_X, K_Y, K_Y};
      exp = '{E_SOC, 1, E_ERR, E_EOC};
      base = log_q.size();
      send_list(seq, 128, 50);
      idle(300);
      n = log_q.size() - base;
      total++;
      if (n !== exp.size()) begin
         bad++;
         $display("FAIL xz_count: got=%0d want=%0d", n, exp.size());
      end
      for (int i = 0; i < n && i < exp.size(); i++) begin
         total++;
         if (log_q[base + i] !== exp[i]) begin
            bad++;
            $display("FAIL xz_event[%0d]: got=%0d want=%0d", i, log_q[base + i], exp[i]);
         end
      end
      if (n >= 3) begin
         total++;
         if (stamp_q[base + 2] - stamp_q[base + 1] !== 1) begin
            bad++;
            $display("FAIL xz_error_gap: got=%0d cycles want=1", stamp_q[base + 2] - stamp_q[base + 1]);
         end
      end
   endtask

   task automatic test_double_pause();
      int seq[$];
      int exp[$];
      int base, n;
      seq = '{K_Z, K_ZX, K_Y, K_Y};
      exp = '{E_SOC, E_ERR, E_EOC};
      base = log_q.size();
      send_list(seq, 128, 20);
      idle(300);
      n = log_q.size() - base;
      total++;
      if (n !== exp.size()) begin
         bad++;
         $display("FAIL dbl_count: got=%0d want=%0d", n, exp.size());
      end
      for (int i = 0; i < n && i < exp.size(); i++) begin
         total++;
         if (log_q[base + i] !== exp[i]) begin
            bad++;
            $display("FAIL dbl_event[%0d]: got=%0d want=%0d", i, log_q[base + i], exp[i]);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      int seq[$];
      int exp[$];
      int base, n;
      seq = '{K_Z, K_X};
      send_list(seq, 128, 20);
      base = log_q.size();
      // Reset with the line held low: no event during or after release.
      pause_n = 1'b0;
      rst_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         total++;
         if ({soc, eoc, data, data_valid, error} !== 5'b0) begin
            bad++;
            $display("FAIL midreset_outputs: got=%b want=00000", {soc, eoc, data, data_valid, error});
         end
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         pause_n = 1'b0;
      end
      idle(300);
      total++;
      if (log_q.size() !== base) begin
         bad++;
         $display("FAIL midreset_quiet: got=%0d events want=0", log_q.size() - base);
      end
      // Fresh frame; soc must land exactly one cycle after the first low sample.
      @(posedge clk);
      #1;
      pause_n = 1'b0;
      @(negedge clk);
      total++;
      if (soc !== 1'b0) begin
         bad++;
         $display("FAIL soc_early: got=%b want=0", soc);
      end
      @(negedge clk);
      total++;
      if (soc !== 1'b1) begin
         bad++;
         $display("FAIL soc_latency: got=%b want=1", soc);
      end
      for (int i = 2; i < 128; i++) begin
         @(posedge clk);
         #1;
         pause_n = (i >= 20);
      end
      seq = '{K_X, K_Y, K_Y};
      exp = '{E_SOC, 1, E_EOC};
      send_list(seq, 128, 20);
      idle(300);
      n = log_q.size() - base;
      total++;
      if (n !== exp.size()) begin
         bad++;
         $display("FAIL fresh_count: got=%0d want=%0d", n, exp.size());
      end
      for (int i = 0; i < n && i < exp.size(); i++) begin
         total++;
         if (log_q[base + i] !== exp[i]) begin
            bad++;
            $display("FAIL fresh_event[%0d]: got=%0d want=%0d", i, log_q[base + i], exp[i]);
         end
      end
   endtask

   task automatic test_jitter_frames();
      logic [11:0] pats[4];
      int plens[3];
      pats[0] = 12'b1011_0011_1010;
      pats[1] = 12'b0000_0000_0000;
      pats[2] = 12'b1111_1111_1111;
      pats[3] = 12'b0100_1101_0001;
      plens[0] = 14;
      plens[1] = 32;
      plens[2] = 50;
      for (int len = 126; len <= 130; len++) begin
         for (int p = 0; p < 3; p++) begin
            int seq[$];
            int exp[$];
            int base, n;
            logic [11:0] pat;
            logic last_one;
            pat = pats[(len + p) % 4];
            last_one = 1'b0;
            seq.push_back(K_Z);
            exp.push_back(E_SOC);
            for (int j = 11; j >= 0; j--) begin
               if (pat[j]) seq.push_back(K_X);
               else        seq.push_back(last_one ? K_Y : K_Z);
               last_one = pat[j];
               exp.push_back(int'(pat[j]));
            end
            seq.push_back(last_one ? K_Y : K_Z);
            seq.push_back(K_Y);
            exp.push_back(E_EOC);
            base = log_q.size();
            send_list(seq, len, plens[p]);
            idle(300);
            n = log_q.size() - base;
            total++;
            if (n !== exp.size()) begin
               bad++;
               $display("FAIL jitter_count L=%0d P=%0d: got=%0d want=%0d", len, plens[p], n, exp.size());
            end
            for (int i = 0; i < n && i < exp.size(); i++) begin
               total++;
               if (log_q[base + i] !== exp[i]) begin
                  bad++;
                  $display("FAIL jitter_event L=%0d P=%0d [%0d]: got=%0d want=%0d",
                           len, plens[p], i, log_q[base + i], exp[i]);
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_eoc_absorb();
      test_error_after_x();
      test_double_pause();
      test_reset_mid_frame();
      test_jitter_frames();
      total++;
      if (viol !== 0) begin
         bad++;
         $display("FAIL pulse_rules: got=%0d violations want=0", viol);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
